// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - registered immediate generator with opcode decoder and 2-entry result FIFO
// Results are built at push time and held in a two-slot shift FIFO; slot 0 is always the head.
module immgen_pipe #(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [2:0]      i_immsel,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal,
  output logic [31:0]     o_inst
);

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_U = 3'b101;
  localparam logic [2:0] FMT_Z = 3'b110;
  localparam logic [2:0] FMT_X = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [31:0]     inst;
  } entry_t;

  logic [2:0]  fmt_dec;
  logic [2:0]  fmt_sel;
  logic [31:0] imm32;
  entry_t      new_ent;

  entry_t      slot0_q, slot0_d;
  entry_t      slot1_q, slot1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rdy_en_q;
  logic        push, pop;

  always_comb begin
    fmt_dec = FMT_X;
    case (i_inst[6:0])
      7'b0110011:                         fmt_dec = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt_dec = FMT_I;
      7'b1110011:                         fmt_dec = i_inst[14] ? FMT_Z : FMT_I;
      7'b0100011:                         fmt_dec = FMT_S;
      7'b1100011:                         fmt_dec = FMT_B;
      7'b1101111:                         fmt_dec = FMT_J;
      7'b0110111, 7'b0010111:             fmt_dec = FMT_U;
      default:                            fmt_dec = FMT_X;
    endcase
  end

  assign fmt_sel = AUTO_SEL ? fmt_dec : i_immsel;

  // Every format fits a sign-correct 32-bit value; widening to XLEN replicates bit 31.
  always_comb begin
    imm32 = 32'd0;
    case (fmt_sel)
      FMT_I:   imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                        i_inst[11:8], 1'b0};
      FMT_J:   imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                        i_inst[30:21], 1'b0};
      FMT_U:   imm32 = {i_inst[31:12], 12'd0};
      FMT_Z:   imm32 = {27'd0, i_inst[19:15]};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    new_ent          = '0;
    new_ent.imm      = {XLEN{imm32[31]}};
    new_ent.imm[31:0] = imm32;
    new_ent.fmt      = fmt_sel;
    new_ent.ill      = (fmt_sel == FMT_X);
    new_ent.inst     = i_inst;
  end

  assign o_ready = rdy_en_q & (cnt_q != 2'd2);
  assign o_valid = (cnt_q != 2'd0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      // Only reachable with one entry held, so the new entry becomes the head.
      slot0_d = new_ent;
    end else if (push) begin
      if (cnt_q == 2'd0) slot0_d = new_ent;
      else               slot1_d = new_ent;
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      if (cnt_q == 2'd2) slot0_d = slot1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      cnt_q    <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign o_imm     = slot0_q.imm;
  assign o_fmt     = slot0_q.fmt;
  assign o_illegal = slot0_q.ill;
  assign o_inst    = slot0_q.inst;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - directed-vector bench for immgen_pipe
// Three instances share all inputs: 32-bit auto, 64-bit auto, 32-bit manual select.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready;
  logic [31:0] inst;
  logic [2:0]  immsel;

  logic        a_ready, a_valid, a_ill;
  logic [31:0] a_imm, a_inst;
  logic [2:0]  a_fmt;
  logic        w_ready, w_valid, w_ill;
  logic [63:0] w_imm;
  logic [31:0] w_inst;
  logic [2:0]  w_fmt;
  logic        m_ready, m_valid, m_ill;
  logic [31:0] m_imm, m_inst;
  logic [2:0]  m_fmt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .AUTO_SEL(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(a_ready),
    .i_inst(inst), .i_immsel(immsel), .o_valid(a_valid), .i_ready(ready),
    .o_imm(a_imm), .o_fmt(a_fmt), .o_illegal(a_ill), .o_inst(a_inst));

  immgen_pipe #(.XLEN(64), .AUTO_SEL(1'b1)) u_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(w_ready),
    .i_inst(inst), .i_immsel(immsel), .o_valid(w_valid), .i_ready(ready),
    .o_imm(w_imm), .o_fmt(w_fmt), .o_illegal(w_ill), .o_inst(w_inst));

  immgen_pipe #(.XLEN(32), .AUTO_SEL(1'b0)) u_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(m_ready),
    .i_inst(inst), .i_immsel(immsel), .o_valid(m_valid), .i_ready(ready),
    .o_imm(m_imm), .o_fmt(m_fmt), .o_illegal(m_ill), .o_inst(m_inst));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic head_a(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                        input logic ill, input logic [31:0] ins);
    chk({tag, ".valid"}, 64'(a_valid), 64'd1);
    chk({tag, ".imm"},   64'(a_imm),   64'(imm));
    chk({tag, ".fmt"},   64'(a_fmt),   64'(fmt));
    chk({tag, ".ill"},   64'(a_ill),   64'(ill));
    chk({tag, ".inst"},  64'(a_inst),  64'(ins));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0;
    inst = 32'd0; immsel = 3'b000;
    tick; tick;
    chk("rst.valid", 64'(a_valid), 64'd0);
    chk("rst.ready", 64'(a_ready), 64'd0);
    chk("rst.imm",   64'(a_imm),   64'd0);
    chk("rst.fmt",   64'(a_fmt),   64'd0);
    chk("rst.ill",   64'(a_ill),   64'd0);
    chk("rst.inst",  64'(a_inst),  64'd0);
    rst_n = 1'b1;
    tick;
    chk("rel.ready", 64'(a_ready), 64'd1);

    // addi x1,x0,-1
    ready = 1'b1; valid = 1'b1; inst = 32'hFFF00093;
    tick;
    head_a("addi", 32'hFFFFFFFF, 3'b001, 1'b0, 32'hFFF00093);

    // beq -4 then lui on consecutive cycles
    inst = 32'hFE000EE3;
    tick;
    head_a("beq", 32'hFFFFFFFC, 3'b011, 1'b0, 32'hFE000EE3);
    inst = 32'h12345037;
    tick;
    head_a("lui", 32'h12345000, 3'b101, 1'b0, 32'h12345037);

    // 64-bit sign extension, CSR uimm, unknown opcode
    inst = 32'h800000B7;
    tick;
    chk("w.lui.imm", w_imm, 64'hFFFFFFFF80000000);
    chk("w.lui.fmt", 64'(w_fmt), 64'd5);
    chk("a.lui.imm", 64'(a_imm), 64'h80000000);
    inst = 32'h3401D073;
    tick;
    chk("w.csr.imm", w_imm, 64'd3);
    chk("w.csr.fmt", 64'(w_fmt), 64'd6);
    chk("w.csr.ill", 64'(w_ill), 64'd0);
    inst = 32'h0000007F;
    tick;
    chk("w.bad.imm", w_imm, 64'd0);
    chk("w.bad.fmt", 64'(w_fmt), 64'd7);
    chk("w.bad.ill", 64'(w_ill), 64'd1);
    valid = 1'b0;
    tick;
    chk("drain.valid", 64'(a_valid), 64'd0);

    // Back-pressure: three offers with the consumer stalled
    ready = 1'b0; valid = 1'b1; inst = 32'h00100093;
    tick;
    chk("bp1.ready", 64'(a_ready), 64'd1);
    head_a("bp1", 32'd1, 3'b001, 1'b0, 32'h00100093);
    inst = 32'h00200093;
    tick;
    chk("bp2.ready", 64'(a_ready), 64'd0);
    head_a("bp2", 32'd1, 3'b001, 1'b0, 32'h00100093);
    inst = 32'h00300093;
    tick;
    chk("bp3.ready", 64'(a_ready), 64'd0);
    head_a("bp3", 32'd1, 3'b001, 1'b0, 32'h00100093);
    ready = 1'b1;
    tick;
    head_a("out2", 32'd2, 3'b001, 1'b0, 32'h00200093);
    tick;
    head_a("out3", 32'd3, 3'b001, 1'b0, 32'h00300093);
    valid = 1'b0;
    tick;
    chk("bp.empty", 64'(a_valid), 64'd0);

    // Flush with a full FIFO beats the offered push
    ready = 1'b0; valid = 1'b1; inst = 32'h00400093;
    tick;
    inst = 32'h00500093;
    tick;
    chk("fl.full", 64'(a_ready), 64'd0);
    flush = 1'b1; inst = 32'h00600093;
    tick;
    chk("fl.valid", 64'(a_valid), 64'd0);
    chk("fl.ready", 64'(a_ready), 64'd1);
    flush = 1'b0; valid = 1'b0;
    tick;
    chk("fl.stay", 64'(a_valid), 64'd0);
    ready = 1'b1; valid = 1'b1; inst = 32'h00700093;
    tick;
    head_a("fl.next", 32'd7, 3'b001, 1'b0, 32'h00700093);
    valid = 1'b0;
    tick;

    // Manual select on sw x1,8(x2), then reset with one entry held
    ready = 1'b0; valid = 1'b1; inst = 32'h00112423; immsel = 3'b010;
    tick;
    valid = 1'b0;
    chk("m.sw.imm", 64'(m_imm), 64'd8);
    chk("m.sw.fmt", 64'(m_fmt), 64'd2);
    chk("a.sw.imm", 64'(a_imm), 64'd8);
    rst_n = 1'b0;
    tick;
    chk("mrst.valid", 64'(m_valid), 64'd0);
    chk("mrst.ready", 64'(m_ready), 64'd0);
    chk("mrst.imm",   64'(m_imm),   64'd0);
    chk("mrst.fmt",   64'(m_fmt),   64'd0);
    chk("mrst.inst",  64'(m_inst),  64'd0);
    rst_n = 1'b1;
    tick;
    chk("mrel.ready", 64'(m_ready), 64'd1);
    chk("mrel.valid", 64'(m_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
